sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/arm_pkg.sv | 28 ++
 rtl/sram_wait_counter.sv | 29 ++
 rtl/sram_controller.sv | 149 ++++++++++++++
 tb/tb_sram_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the SRAM interface of the ARM datapath.
// Holds the SRAM FSM state encoding, the SRAM geometry and the
// address-range helper used by the controller.
package arm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } sram_state_e;

  localparam int SRAM_BASE_ADDR = 1024;
  localparam int SRAM_ADDR_W    = 18;
  localparam int SRAM_DATA_W    = 16;
  localparam int SRAM_WAIT_W    = 4;

  // Byte-address window backed by the SRAM: 2^(SRAM_ADDR_W+1) bytes above the base.
  localparam logic [31:0] SRAM_LIMIT_ADDR = 32'(SRAM_BASE_ADDR) + (32'd1 << (SRAM_ADDR_W + 1));

  // True when a byte address falls outside the SRAM window.
  function automatic logic sram_addr_out_of_range(input logic [31:0] addr);
    return (addr < 32'(SRAM_BASE_ADDR)) || (addr >= SRAM_LIMIT_ADDR);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer for the SRAM controller: loadable down-counter that
// stops at zero and flags terminal count while it sits there.
module sram_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load takes precedence over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// 32-bit load/store front end for a 16-bit asynchronous SRAM.
// Each access is split into a low and a high halfword phase, each held
// for SRAM_WAIT cycles; ready drops combinationally with the request so
// the pipeline freezes in the same cycle.
// Optional feature: define SRAM_ADDR_CHECK_EN to reject addresses outside
// the SRAM window (straight to DONE with a one-cycle addr_err pulse).
module sram_controller
  import arm_pkg::*;
#(
  parameter int SRAM_WAIT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_en,
  input  logic                   mem_write_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   addr_err
);

  localparam logic [SRAM_WAIT_W-1:0] WAIT_LOAD = SRAM_WAIT_W'(SRAM_WAIT - 1);

  sram_state_e state;
  sram_state_e state_next;

  logic                   req_any;
  logic                   phase_tc;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic [31:0]            addr_off;
  logic [SRAM_ADDR_W-2:0] word_off;
  logic                   addr_off_unused;

  assign req_any = mem_read_en | mem_write_en;

  // Offset wraps modulo 2^32 before the word shift; only the low word bits reach the SRAM.
  assign addr_off        = address - 32'(SRAM_BASE_ADDR);
  assign word_off        = addr_off[SRAM_ADDR_W:2];
  assign addr_off_unused = ^{addr_off[31:SRAM_ADDR_W+1], addr_off[1:0]};

  // Reload the phase timer on every state change, count down while a phase is held.
  assign cnt_load = (state_next != state);
  assign cnt_dec  = ~cnt_load;

  sram_wait_counter #(
    .WIDTH(SRAM_WAIT_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .tc       (phase_tc)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: requests are only looked at in IDLE, write wins over read.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_any) begin
`ifdef SRAM_ADDR_CHECK_EN
          if (sram_addr_out_of_range(address)) begin
            state_next = DONE;
          end else
`endif
          if (mem_write_en) begin
            state_next = WR_LO;
          end else begin
            state_next = RD_LO;
          end
        end
      end
      RD_LO:   if (phase_tc) state_next = RD_HI;
      RD_HI:   if (phase_tc) state_next = DONE;
      WR_LO:   if (phase_tc) state_next = WR_HI;
      WR_HI:   if (phase_tc) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SRAM pin drive decoded from the current phase; everything idles low/inactive.
  always_comb begin
    ready       = ((state == IDLE) && !req_any) || (state == DONE);
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    unique case (state)
      RD_LO: sram_addr = {word_off, 1'b0};
      RD_HI: sram_addr = {word_off, 1'b1};
      WR_LO: begin
        sram_addr   = {word_off, 1'b0};
        sram_dq_out = write_data[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      WR_HI: begin
        sram_addr   = {word_off, 1'b1};
        sram_dq_out = write_data[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      default: ;
    endcase
  end

  // Capture each returned halfword on the final cycle of its phase; held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
    end else if ((state == RD_LO) && phase_tc) begin
      read_data[15:0] <= sram_dq_in;
    end else if ((state == RD_HI) && phase_tc) begin
      read_data[31:16] <= sram_dq_in;
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  // One-cycle error flag, visible in the DONE cycle of a rejected request.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= (state == IDLE) && req_any && sram_addr_out_of_range(address);
    end
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed cases followed by random loads and
// stores, checked cycle by cycle against a word-level memory model.
module tb_sram_controller;

  localparam int W    = 2;
  localparam int LAST = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        addr_err;

  always #5 clk = ~clk;

  sram_controller #(.SRAM_WAIT(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .ready        (ready),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_in   (sram_dq_in),
    .sram_dq_oe   (sram_dq_oe),
    .sram_we_n    (sram_we_n),
    .addr_err     (addr_err)
  );

  // Halfword SRAM device model.
  logic [15:0] sram_mem [0:262143];
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] word_map [int];
  logic [31:0] exp_rd;

  function automatic logic [15:0] pat(int i);
    logic [31:0] t;
    t = i * 32'd40503 + 32'd4660;
    return t[15:0];
  endfunction

  // Word index seen by the SRAM: (address - 1024) / 4, modulo 2^17 words.
  function automatic int key_of(logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'd1024) >> 2;
    return int'(d[16:0]);
  endfunction

  function automatic logic [31:0] exp_word(int k);
    if (word_map.exists(k)) return word_map[k];
    return {pat(2 * k + 1), pat(2 * k)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access from the request cycle through DONE; request stays held throughout.
  task automatic txn(bit wr, bit rd, logic [31:0] a, logic [31:0] d);
    int          k0;
    int          last;
    bit          skip;
    logic [16:0] kw;
    k0   = key_of(a);
    kw   = k0[16:0];
    skip = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
    skip = (a < 32'd1024) || (a >= 32'd525312);
`endif
    last = skip ? 1 : LAST;
    mem_write_en = wr;
    mem_read_en  = rd;
    address      = a;
    write_data   = d;
    for (int k = 0; k <= last; k++) begin
      bit          lo;
      bit          hi;
      logic [17:0] ea;
      logic [15:0] ed;
      lo = !skip && (k >= 1) && (k <= W);
      hi = !skip && (k > W) && (k <= 2 * W);
      ea = lo ? {kw, 1'b0} : (hi ? {kw, 1'b1} : 18'd0);
      ed = (wr && lo) ? d[15:0] : ((wr && hi) ? d[31:16] : 16'd0);
      @(negedge clk);
      check("ready", 32'(ready), 32'(k == last));
      check("sram_addr", 32'(sram_addr), 32'(ea));
      check("we_n", 32'(sram_we_n), 32'(!(wr && (lo || hi))));
      check("dq_oe", 32'(sram_dq_oe), 32'(wr && (lo || hi)));
      check("dq_out", 32'(sram_dq_out), 32'(ed));
      check("addr_err", 32'(addr_err), 32'(skip && (k == last)));
      if (k == last) begin
        if (rd && !wr && !skip) exp_rd = exp_word(k0);
        check("read_data", read_data, exp_rd);
      end
      @(posedge clk);
      #1;
    end
    if (wr && !skip) word_map[k0] = d;
  endtask

  task automatic idle(int n);
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(sram_we_n), 32'd1);
      check("idle_addr", 32'(sram_addr), 32'd0);
      check("idle_read_data", read_data, exp_rd);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    for (int i = 0; i < 262144; i++) sram_mem[i] = pat(i);
    rst          = 1'b1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    address      = '0;
    write_data   = '0;
    exp_rd       = '0;

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Store of 0xDEADBEEF at the base address.
    txn(1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF);
    idle(1);
    check("store_lo_mem", 32'(sram_mem[0]), 32'h0000_BEEF);
    check("store_hi_mem", 32'(sram_mem[1]), 32'h0000_DEAD);

    // Load of a preloaded word at 0x404.
    sram_mem[2] = 16'h1234;
    sram_mem[3] = 16'hABCD;
    word_map[1] = 32'hABCD_1234;
    txn(1'b0, 1'b1, 32'h0000_0404, 32'h0);
    idle(2);
    check("load_value", read_data, 32'hABCD_1234);

    // Simultaneous read and write: write only, read_data untouched.
    txn(1'b1, 1'b1, 32'h0000_0408, 32'h5555_AAAA);
    idle(1);

    // Address below the window: wraps in the default build, rejected with the check enabled.
    txn(1'b0, 1'b1, 32'h0000_03FC, 32'h0);
    idle(1);

    // Back-to-back load then store with no idle cycle between them.
    txn(1'b0, 1'b1, 32'h0000_0400, 32'h0);
    txn(1'b1, 1'b0, 32'h0000_040C, 32'h0BAD_F00D);
    idle(1);

    // Reset in the second RD_HI cycle aborts the load.
    mem_read_en  = 1'b1;
    mem_write_en = 1'b0;
    address      = 32'h0000_0410;
    for (int k = 0; k < 2 * W; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    mem_read_en = 1'b0;
    exp_rd      = '0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_read_data", read_data, 32'd0);
    check("abort_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_addr", 32'(sram_addr), 32'd0);
    @(posedge clk);
    #1;
    idle(1);

    // Random loads and stores over a small window plus occasional arbitrary addresses.
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4;
      d = $urandom;
      txn(op == 1 || op == 2, op != 1, a, d);
      idle(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
